mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 3, giving the cycles from request to mem_resp; legal range 1..15.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 8, giving a backing store of 2**DEPTH_LOG2 32-bit words.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h40000000, giving the byte address of word 0.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mem_read  in  1  read request; held by the initiator until mem_resp.
REQ-007 mem_write  in  1  write request; held by the initiator until mem_resp.
REQ-008 mem_byte_enable  in  4  write lane mask; bit i selects bits [8i+7:8i].
REQ-009 mem_address  in  32  byte address; bits [1:0] ignored.
REQ-010 mem_wdata  in  32  write data.
REQ-011 mem_rdata  out  32  read data; valid in the mem_resp cycle.
REQ-012 mem_resp  out  1  one-cycle completion pulse.
REQ-013 mem_err  out  1  error flag; meaningful only with mem_resp.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-015 In IDLE, a cycle with mem_read or mem_write high SHALL accept a request, capture address, wdata, byte_enable and op, and move to BUSY (or to RESP when LATENCY==1).
REQ-016 After acceptance, request inputs SHALL be ignored until the FSM returns to IDLE.
REQ-017 BUSY SHALL count down a 4-bit counter loaded with LATENCY-2 and move to RESP when the count is 0.
REQ-018 For a request first high in cycle t, mem_resp SHALL be high in cycle t+LATENCY only, for exactly one cycle.
REQ-019 RESP SHALL always move to IDLE on the next cycle.
REQ-020 A request still high in the cycle after RESP SHALL be treated as a new request.
REQ-021 Word index SHALL be (addr - BASE_ADDR) >> 2.
REQ-022 An address is out of range when addr < BASE_ADDR or index >= 2**DEPTH_LOG2; that request SHALL complete with mem_err=1, no store update, and mem_rdata=0.
REQ-023 mem_read and mem_write both high at acceptance SHALL complete with mem_err=1, no store update, and mem_rdata=0.
REQ-024 A legal write SHALL update only the enabled byte lanes, on the edge that raises mem_resp; mem_byte_enable=0 SHALL complete with no change and mem_err=0.
REQ-025 A legal read SHALL drive mem_rdata with the store word during the RESP cycle, including any write committed earlier.
REQ-026 mem_rdata SHALL hold its last driven value outside RESP.
REQ-027 A write SHALL leave mem_rdata unchanged.
REQ-028 mem_err SHALL be 0 whenever mem_resp is 0.

Reset
REQ-029 rst SHALL force state IDLE, counter 0, mem_resp=0, mem_err=0, mem_rdata=0, and clear every store word to 0.
REQ-030 rst during BUSY or RESP SHALL abort the request: no store update and no mem_resp on any later cycle for that request.
REQ-031 rst SHALL take priority over any simultaneous request.

Verification
REQ-032 Read after reset, LATENCY=3: mem_read, addr 0x40000010, raised in cycle 5 -> mem_resp only in cycle 8, mem_rdata=0, mem_err=0.
REQ-033 Write 0xAABBCCDD, be=4'b0101, to 0x40000004 over a word holding 0x11223344, then read 0x40000004 -> mem_rdata=0x11BB33DD.
REQ-034 mem_read at addr 0x3FFFFFFC, and at 0x40000400 with DEPTH_LOG2=8 -> mem_resp with mem_err=1 and mem_rdata=0 for each; store unchanged.
REQ-035 mem_read and mem_write both high -> mem_err=1; mem_write alone with be=0 -> mem_err=0 and word unchanged.
REQ-036 rst pulsed one cycle after a write to 0x40000000 is accepted -> no mem_resp; a later read of 0x40000000 returns 0.
REQ-037 LATENCY=1 with back-to-back held requests -> mem_resp every other cycle; cycles between responses show mem_resp=0.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one read/write at a time, answers after LATENCY cycles.
// Backing store is a register array so reset can clear every word in one cycle.
module mem_responder #(
  parameter int          LATENCY    = 3,
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         SINGLE   = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_reg;
  logic [3:0]            cnt_reg;
  logic                  write_reg;
  logic                  err_reg;
  logic [DEPTH_LOG2-1:0] idx_reg;
  logic [31:0]           wdata_reg;
  logic [3:0]            be_reg;

  logic [31:0]           store [DEPTH];

  logic                  req;
  logic [29:0]           word_off;
  logic                  acc_err;
  logic                  fin_write;
  logic                  fin_err;
  logic [DEPTH_LOG2-1:0] fin_idx;
  logic [31:0]           fin_wdata;
  logic [3:0]            fin_be;
  logic [31:0]           lane_mask;
  logic                  go_resp;
  logic                  store_we;

  assign req      = mem_read || mem_write;
  assign word_off = mem_address[31:2] - BASE_ADDR[31:2];
  assign acc_err  = (mem_address < BASE_ADDR) || ((word_off >> DEPTH_LOG2) != 30'd0) ||
                    (mem_read && mem_write);

  // With LATENCY==1 the request completes on its acceptance edge, so use the live inputs.
  always_comb begin
    fin_write = write_reg;
    fin_err   = err_reg;
    fin_idx   = idx_reg;
    fin_wdata = wdata_reg;
    fin_be    = be_reg;
    if (state_reg == IDLE) begin
      fin_write = mem_write;
      fin_err   = acc_err;
      fin_idx   = word_off[DEPTH_LOG2-1:0];
      fin_wdata = mem_wdata;
      fin_be    = mem_byte_enable;
    end
  end

  assign go_resp  = ((state_reg == IDLE) && req && SINGLE) ||
                    ((state_reg == BUSY) && (cnt_reg == 4'd0));
  assign store_we = go_resp && fin_write && !fin_err;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[8*gi +: 8] = {8{fin_be[gi]}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= 32'd0;
    end else if (store_we) begin
      store[fin_idx] <= (store[fin_idx] & ~lane_mask) | (fin_wdata & lane_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= 32'd0;
      be_reg    <= 4'd0;
      mem_rdata <= 32'd0;
      mem_resp  <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      mem_err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            write_reg <= mem_write;
            err_reg   <= acc_err;
            idx_reg   <= word_off[DEPTH_LOG2-1:0];
            wdata_reg <= mem_wdata;
            be_reg    <= mem_byte_enable;
            cnt_reg   <= CNT_LOAD;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
        end
        default: state_reg <= IDLE;
      endcase
      if (go_resp) begin
        state_reg <= RESP;
        mem_resp  <= 1'b1;
        mem_err   <= fin_err;
        if (fin_err)         mem_rdata <= 32'd0;
        else if (!fin_write) mem_rdata <= store[fin_idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=3 instance for function, LATENCY=1 instance for back-to-back.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp, mem_err;

  logic        rd1, wr1;
  logic [3:0]  be1;
  logic [31:0] addr1, wdata1;
  logic [31:0] rdata1;
  logic        resp1, err1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(3), .DEPTH_LOG2(8), .BASE_ADDR(32'h4000_0000)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_err(mem_err)
  );

  mem_responder #(.LATENCY(1), .DEPTH_LOG2(8), .BASE_ADDR(32'h4000_0000)) dut1 (
    .clk(clk), .rst(rst),
    .mem_read(rd1), .mem_write(wr1), .mem_byte_enable(be1),
    .mem_address(addr1), .mem_wdata(wdata1),
    .mem_rdata(rdata1), .mem_resp(resp1), .mem_err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request on the LATENCY=3 instance, hold it until mem_resp, then check the response.
  task automatic do_req(input string name, input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int          k = 0;
    bit          seen = 0;
    logic [31:0] rv = 32'hx;
    logic        ev = 1'bx;
    mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_address = a; mem_wdata = d;
    while (!seen && k < 20) begin
      tick();
      k++;
      if (mem_resp) begin
        seen = 1; rv = mem_rdata; ev = mem_err;
        mem_read = 1'b0; mem_write = 1'b0;
      end else begin
        chk({name, "_err_idle"}, 32'(mem_err), 32'd0);
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    chk({name, "_seen"}, 32'(seen), 32'd1);
    chk({name, "_lat"}, k, 32'd3);
    chk({name, "_rdata"}, rv, exp_rdata);
    chk({name, "_err"}, 32'(ev), 32'(exp_err));
    tick();
    chk({name, "_pulse"}, 32'(mem_resp), 32'd0);
    chk({name, "_err_after"}, 32'(mem_err), 32'd0);
    $display("txn %s rd=%0b wr=%0b be=%b addr=0x%08h wdata=0x%08h lat=%0d rdata=0x%08h err=%0b",
             name, rd, wr, be, a, d, k, rv, ev);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    mem_read = 0; mem_write = 0; mem_byte_enable = 0; mem_address = 0; mem_wdata = 0;
    rd1 = 0; wr1 = 0; be1 = 0; addr1 = 0; wdata1 = 0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_resp", 32'(mem_resp), 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);
    chk("reset_rdata", mem_rdata, 32'd0);
    tick(); tick();

    do_req("rd_after_reset", 1, 0, 4'h0, 32'h4000_0010, 32'h0, 32'h0, 0);
    do_req("wr_full",        0, 1, 4'hF, 32'h4000_0004, 32'h1122_3344, 32'h0, 0);
    do_req("rd_full",        1, 0, 4'h0, 32'h4000_0004, 32'h0, 32'h1122_3344, 0);
    do_req("wr_lanes",       0, 1, 4'b0101, 32'h4000_0004, 32'hAABB_CCDD, 32'h1122_3344, 0);
    do_req("rd_lanes",       1, 0, 4'h0, 32'h4000_0004, 32'h0, 32'h11BB_33DD, 0);
    do_req("rd_below",       1, 0, 4'h0, 32'h3FFF_FFFC, 32'h0, 32'h0, 1);
    do_req("rd_lanes2",      1, 0, 4'h0, 32'h4000_0007, 32'h0, 32'h11BB_33DD, 0);
    do_req("rd_above",       1, 0, 4'h0, 32'h4000_0400, 32'h0, 32'h0, 1);
    do_req("wr_above",       0, 1, 4'hF, 32'h4000_0400, 32'hCAFE_F00D, 32'h0, 1);
    do_req("rd_word0",       1, 0, 4'h0, 32'h4000_0000, 32'h0, 32'h0, 0);
    do_req("wr_last",        0, 1, 4'hF, 32'h4000_03FC, 32'h1234_5678, 32'h0, 0);
    do_req("rd_last",        1, 0, 4'h0, 32'h4000_03FC, 32'h0, 32'h1234_5678, 0);
    do_req("rd_wr_both",     1, 1, 4'hF, 32'h4000_0004, 32'h0, 32'h0, 1);
    do_req("rd_after_both",  1, 0, 4'h0, 32'h4000_0004, 32'h0, 32'h11BB_33DD, 0);
    do_req("wr_be0",         0, 1, 4'h0, 32'h4000_0004, 32'h0, 32'h11BB_33DD, 0);
    do_req("rd_after_be0",   1, 0, 4'h0, 32'h4000_0004, 32'h0, 32'h11BB_33DD, 0);

    // Abort: write accepted at one edge, reset sampled at the next.
    mem_write = 1; mem_byte_enable = 4'hF; mem_address = 32'h4000_0000; mem_wdata = 32'hDEAD_BEEF;
    tick();
    mem_write = 0; rst = 1'b1;
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_resp) pulses++;
      tick();
    end
    chk("abort_no_resp", pulses, 32'd0);
    $display("txn abort_write addr=0x40000000 pulses=%0d", pulses);
    do_req("rd_after_abort", 1, 0, 4'h0, 32'h4000_0000, 32'h0, 32'h0, 0);
    do_req("rd_cleared",     1, 0, 4'h0, 32'h4000_0004, 32'h0, 32'h0, 0);

    // LATENCY=1: a held read is re-accepted every other cycle.
    rd1 = 1; addr1 = 32'h4000_0000;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("lat1_resp_%0d", i), 32'(resp1), 32'(i % 2));
      chk($sformatf("lat1_err_%0d", i), 32'(err1), 32'd0);
      $display("txn lat1 cycle=%0d resp=%0b rdata=0x%08h", i, resp1, rdata1);
    end
    rd1 = 0;
    tick();
    chk("lat1_rdata", rdata1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
